// File: rtl/vga_timing_gen_if.sv
// Signal bundle between the VGA timing generator, the game logic and the pins.
// The master side is the timing generator; the slave side supplies colour and observes the raster.
interface vga_timing_gen_if;
    logic [3:0]  red_in;
    logic [3:0]  green_in;
    logic [3:0]  blue_in;
    logic [9:0]  h_coord;
    logic [9:0]  v_coord;
    logic        hsync;
    logic        vsync;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic        display_on;
    logic        frame_start;
    logic [15:0] frame_cnt;

    modport master (
        input  red_in, green_in, blue_in,
        output h_coord, v_coord, hsync, vsync, red, green, blue,
        output display_on, frame_start, frame_cnt
    );

    modport slave (
        output red_in, green_in, blue_in,
        input  h_coord, v_coord, hsync, vsync, red, green, blue,
        input  display_on, frame_start, frame_cnt
    );
endinterface

// File: rtl/vga_timing_gen.sv
// 800x600@56Hz raster timing generator with registered, mutually aligned sync/colour pins.
// Optional macro VGA_TEST_PATTERN_EN replaces game_logic colour by 8 vertical colour bars.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 800,
    parameter int H_FP       = 24,
    parameter int H_SYNC     = 72,
    parameter int H_BP       = 128,
    parameter int V_ACTIVE   = 600,
    parameter int V_FP       = 1,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 22,
    parameter bit H_SYNC_POL = 1'b1,
    parameter bit V_SYNC_POL = 1'b1
) (
    input  logic              pixel_clk,
    input  logic              rst,
    vga_timing_gen_if.master  vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0]  h_q, h_d;
    logic [9:0]  v_q, v_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic [3:0]  red_q, red_d;
    logic [3:0]  green_q, green_d;
    logic [3:0]  blue_q, blue_d;
    logic        display_on_q, display_on_d;
    logic        frame_start_q, frame_start_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    logic        h_wrap_s;
    logic        v_wrap_s;
    logic        active_s;
    logic        hs_act_s;
    logic        vs_act_s;
    logic [3:0]  col_r_s;
    logic [3:0]  col_g_s;
    logic [3:0]  col_b_s;

    // Raster counters: v advances only on the cycle h wraps.
    always_comb begin
        h_wrap_s = (h_q == H_LAST);
        v_wrap_s = (v_q == V_LAST);
        h_d      = h_q;
        v_d      = v_q;
        if (h_wrap_s) begin
            h_d = 10'd0;
            if (v_wrap_s) begin
                v_d = 10'd0;
            end else begin
                v_d = v_q + 10'd1;
            end
        end else begin
            h_d = h_q + 10'd1;
            v_d = v_q;
        end
    end

    // Stage-1 decode of the current coordinates.
    always_comb begin
        active_s = (h_q < H_VIS) && (v_q < V_VIS);
        hs_act_s = (h_q >= HS_FIRST) && (h_q <= HS_LAST);
        vs_act_s = (v_q >= VS_FIRST) && (v_q <= VS_LAST);
    end

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar_s;

    // Bar index h/100 built from threshold compares instead of a divider.
    always_comb begin
        bar_s = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (h_q >= 10'(i * 100)) begin
                bar_s = 3'(i);
            end else begin
                bar_s = bar_s;
            end
        end
        col_r_s = {4{bar_s[0]}};
        col_g_s = {4{bar_s[1]}};
        col_b_s = {4{bar_s[2]}};
    end
`else
    // Colour comes straight from game_logic for the current coordinates.
    always_comb begin
        col_r_s = vga.red_in;
        col_g_s = vga.green_in;
        col_b_s = vga.blue_in;
    end
`endif

    // Pin stage next values; everything here lands one clock after the coords.
    always_comb begin
        hsync_d       = hs_act_s ? H_SYNC_POL : ~H_SYNC_POL;
        vsync_d       = vs_act_s ? V_SYNC_POL : ~V_SYNC_POL;
        display_on_d  = active_s;
        red_d         = active_s ? col_r_s : 4'd0;
        green_d       = active_s ? col_g_s : 4'd0;
        blue_d        = active_s ? col_b_s : 4'd0;
        frame_start_d = h_wrap_s && v_wrap_s;
        if (frame_start_d) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // State and pin registers; reset wins over everything on the same edge.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            h_q           <= 10'd0;
            v_q           <= 10'd0;
            hsync_q       <= ~H_SYNC_POL;
            vsync_q       <= ~V_SYNC_POL;
            red_q         <= 4'd0;
            green_q       <= 4'd0;
            blue_q        <= 4'd0;
            display_on_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= 16'd0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
            display_on_q  <= display_on_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign vga.h_coord     = h_q;
    assign vga.v_coord     = v_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.red         = red_q;
    assign vga.green       = green_q;
    assign vga.blue        = blue_q;
    assign vga.display_on  = display_on_q;
    assign vga.frame_start = frame_start_q;
    assign vga.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a shrunken raster so whole frames fit in a short run.
// Expected pins/coords come from an independent raster model pushed into a queue each cycle.
module tb_vga_timing_gen;

    localparam int HA = 20, HF = 3, HS = 4, HB = 5;
    localparam int VA = 6,  VF = 1, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    typedef struct packed {
        logic [9:0]  h;
        logic [9:0]  v;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
        logic        de;
        logic        fs;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    exp_t        sb_q[$];
    int          mh = 0;
    int          mv = 0;
    logic [15:0] mcnt = 16'd0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          hs_run = 0;
    int          vs_run = 0;

    vga_timing_gen_if vif();

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
    ) dut (
        .pixel_clk (clk),
        .rst       (rst),
        .vga       (vif)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (model h=%0d v=%0d)", tag, got, exp, mh, mv);
        end
    endtask

    // One clock: drive inputs, push the model's prediction, then pop and compare at negedge.
    task automatic step(input logic r, input logic [3:0] ri, input logic [3:0] gi, input logic [3:0] bi);
        exp_t e;
        exp_t o;
        logic act;
        logic [3:0] pr, pg, pb;
        rst = r;
        vif.red_in   = ri;
        vif.green_in = gi;
        vif.blue_in  = bi;
        if (r) begin
            e = '0;
            mh = 0;
            mv = 0;
            mcnt = 16'd0;
        end else begin
            act = (mh < HA) && (mv < VA);
`ifdef VGA_TEST_PATTERN_EN
            pr = {4{((mh / 100) % 2) == 1}};
            pg = {4{((mh / 200) % 2) == 1}};
            pb = {4{((mh / 400) % 2) == 1}};
`else
            pr = ri;
            pg = gi;
            pb = bi;
`endif
            e.hs  = (mh >= HA + HF) && (mh < HA + HF + HS);
            e.vs  = (mv >= VA + VF) && (mv < VA + VF + VS);
            e.de  = act;
            e.rgb = act ? {pr, pg, pb} : 12'd0;
            e.fs  = (mh == HT - 1) && (mv == VT - 1);
            if (e.fs) mcnt = mcnt + 16'd1;
            e.cnt = mcnt;
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
            e.h = 10'(mh);
            e.v = 10'(mv);
        end
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        o = sb_q.pop_front();
        check_eq("h_coord",     32'(vif.h_coord), 32'(o.h));
        check_eq("v_coord",     32'(vif.v_coord), 32'(o.v));
        check_eq("hsync",       32'(vif.hsync), 32'(o.hs));
        check_eq("vsync",       32'(vif.vsync), 32'(o.vs));
        check_eq("rgb",         32'({vif.red, vif.green, vif.blue}), 32'(o.rgb));
        check_eq("display_on",  32'(vif.display_on), 32'(o.de));
        check_eq("frame_start", 32'(vif.frame_start), 32'(o.fs));
        check_eq("frame_cnt",   32'(vif.frame_cnt), 32'(o.cnt));
        if (vif.hsync === 1'b1) begin
            hs_run++;
        end else begin
            if (hs_run != 0) check_eq("hsync_width", 32'(hs_run), 32'(HS));
            hs_run = 0;
        end
        if (vif.vsync === 1'b1) begin
            vs_run++;
        end else begin
            if (vs_run != 0) check_eq("vsync_width", 32'(vs_run), 32'(VS * HT));
            vs_run = 0;
        end
    endtask

    initial begin
        vif.red_in   = 4'h0;
        vif.green_in = 4'h0;
        vif.blue_in  = 4'h0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) step(1'b1, 4'hA, 4'hA, 4'hA);

        // Two frames: constant 0xA first, random colour second.
        for (int i = 0; i < 2 * FRAME + 20; i++) begin
            if (i < FRAME) step(1'b0, 4'hA, 4'hA, 4'hA);
            else           step(1'b0, 4'($urandom), 4'($urandom), 4'($urandom));
        end

        // Preload the frame counter to its top value, then cross the next wrap.
        force dut.frame_cnt_q = 16'hFFFF;
        mcnt = 16'hFFFF;
        step(1'b0, 4'h5, 4'h6, 4'h7);
        release dut.frame_cnt_q;
        for (int i = 0; i < FRAME; i++) step(1'b0, 4'($urandom), 4'($urandom), 4'($urandom));

        // Mid-frame reset pulse at (10,3).
        for (int i = 0; i < FRAME && !(mh == 10 && mv == 3); i++) step(1'b0, 4'hC, 4'h3, 4'h9);
        step(1'b1, 4'hF, 4'hF, 4'hF);
        for (int i = 0; i < FRAME + 40; i++) step(1'b0, 4'($urandom), 4'($urandom), 4'($urandom));

        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Produces the 800x600 @ 56 Hz VGA raster for the 36 MHz pixel clock.
- Drives h_coord/v_coord into game_logic and receives its combinational 4-bit RGB back.
- Drives hsync/vsync and blanked RGB pins, delay-matched to each other.
- Also provides a per-frame pulse and a frame counter for top-level bookkeeping.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 24, horizontal front porch (clocks)
- H_SYNC, 72, horizontal sync width (clocks)
- H_BP, 128, horizontal back porch (clocks); H_TOTAL = 1024
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 22, vertical back porch (lines); V_TOTAL = 625
- H_SYNC_POL, 1, hsync active level
- V_SYNC_POL, 1, vsync active level

Ports:
- pixel_clk  in  1  pixel clock, 36 MHz
- rst  in  1  synchronous reset, active-high
- red_in  in  4  colour from game_logic for current coords
- green_in  in  4  colour from game_logic for current coords
- blue_in  in  4  colour from game_logic for current coords
- h_coord  out  10  horizontal counter, 0..H_TOTAL-1
- v_coord  out  10  vertical counter, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, registered
- vsync  out  1  vertical sync, registered
- red  out  4  blanked colour to pins, registered
- green  out  4  blanked colour to pins, registered
- blue  out  4  blanked colour to pins, registered
- display_on  out  1  registered: the pixel now on the pins is visible
- frame_start  out  1  one-cycle pulse at start of each new frame
- frame_cnt  out  16  completed-frame counter

Behaviour:
- Single clock domain: pixel_clk only. rst is synchronous, active-high; it overrides everything on the same edge.
- Reset values:
  - h_coord=0, v_coord=0
  - hsync=!H_SYNC_POL, vsync=!V_SYNC_POL
  - red/green/blue=0, display_on=0
  - frame_start=0, frame_cnt=0
- Horizontal counter:
  - h_coord increments every cycle.
  - At H_TOTAL-1 it wraps to 0 and v_coord advances.
- Vertical counter:
  - v_coord wraps from V_TOTAL-1 to 0.
  - Wrap happens only on the cycle where h_coord also wraps.
- Counters are plain registers, so h_coord/v_coord change exactly on clock edges. game_logic sees (799,599) for exactly one cycle per frame.
- Stage-1 decode from the current coords:
  - active = (h_coord < H_ACTIVE) && (v_coord < V_ACTIVE)
  - hs_act = h_coord in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 824..895
  - vs_act = v_coord in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 601..602
- Output register, one cycle latency:
  - hsync = hs_act ? H_SYNC_POL : !H_SYNC_POL (vsync likewise with vs_act, V_SYNC_POL)
  - display_on = active
  - rgb = active ? *_in : 0
- Pin alignment: sync, display_on and rgb are mutually aligned. All lag h_coord/v_coord by exactly 1 clock.
- Blanking: colour on the pins is forced to 0 outside the active area, regardless of *_in.
- frame_start:
  - Registered; high for the one cycle after the counters wrap from (1023,624) to (0,0), i.e. while h_coord=0, v_coord=0.
  - Not asserted on the first (0,0) following reset.
- frame_cnt: increments by 1 on the same edge frame_start rises; wraps 0xFFFF -> 0x0000.
- Reset mid-frame: counters and all outputs return to reset values on the next edge. Counting restarts at (0,0) with no frame_start pulse.
- Arithmetic:
  - Sync window bounds are computed from the parameters at elaboration time.
  - Comparisons are unsigned, 10-bit.
  - H_TOTAL-1 and V_TOTAL-1 must fit in 10 bits; out-of-range parameters are not supported.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined:
  - *_in is ignored.
  - Active-area colour is 8 vertical bars, 100 px wide, bar index b = h_coord / 100 (0..7).
  - red = {4{b[0]}}, green = {4{b[1]}}, blue = {4{b[2]}}.
  - Timing, blanking and latency are identical to normal mode.
- Undefined: colour passes from *_in as described in Behaviour; no pattern logic is synthesised.

Test Plan:
- Reset, release rst, run 2 frames -> h_coord period 1024 clocks; v_coord period 625 lines = 640000 clocks per frame; no frame_start before the first wrap.
- Monitor sync widths -> hsync high for 72 consecutive clocks, starting 1 clock after h_coord=824; vsync high for 2 lines (v_coord 601..602 plus 1 clock lag); both low otherwise.
- Drive red_in=green_in=blue_in=4'hA constantly -> pins show 4'hA only while display_on=1, i.e. 800 clocks per line on 600 lines; 0 elsewhere, including h_coord 800..1023.
- Run across wrap (1023,624)->(0,0) with frame_cnt preloaded by running 0xFFFF frames (or forced) -> single-cycle frame_start; frame_cnt 0xFFFF -> 0x0000.
- Assert rst for 1 cycle at (500,300) -> next cycle h_coord=0, v_coord=0, hsync=vsync=0, rgb=0, frame_cnt=0; counting resumes cleanly.
- With VGA_TEST_PATTERN_EN: at v_coord=10, h_coord=0,150,350,750 -> pins one cycle later show rgb (0,0,0), (F,0,0), (F,F,0), (F,F,F).
